// File: rtl/sfu_pkg.sv
// Shared types and constants for the special-function unit front end.
package sfu_pkg;

  localparam int EXP_BIAS = 63;

  localparam logic [23:0] FP24_QNAN = 24'h7F8000;
  localparam logic [23:0] FP24_PINF = 24'h7F0000;
  localparam logic [23:0] FP24_ZERO = 24'h000000;
  localparam logic [23:0] FIX_ONE   = 24'h010000;

  typedef enum logic [2:0] {
    SFU_RSQRT = 3'd0,
    SFU_SIN   = 3'd1,
    SFU_COS   = 3'd2
  } sfu_op_e;

  // Side-band that travels with a lookup so the assembly stage can build the result.
  typedef struct packed {
    logic        special;
    logic [23:0] special_val;
    logic        sign;
    logic [6:0]  exp;
    logic        fmt;
  } sfu_sb_t;

endpackage

// File: rtl/sfu_rsqrt_classify.sv
// Combinational RSQRT classifier: special-case detection, ROM address and result exponent.
module sfu_rsqrt_classify #(
  parameter int EXP_BIAS = 63
) (
  input  logic [23:0] operand,
  output logic        special,
  output logic [23:0] special_val,
  output logic [9:0]  addr,
  output logic [6:0]  res_exp
);
  import sfu_pkg::*;

  logic              sign;
  logic [6:0]        e;
  logic [15:0]       m;
  logic signed [7:0] e_unb;
  logic signed [7:0] k;
  logic              p;
  logic signed [7:0] pow4_exp;
  logic signed [7:0] tbl_exp;

  assign sign  = operand[23];
  assign e     = operand[22:16];
  assign m     = operand[15:0];
  assign e_unb = $signed({1'b0, e}) - $signed(8'(EXP_BIAS));
  assign p     = e_unb[0];
  assign k     = e_unb >>> 1;

  // 1/sqrt(2^(2k)) is exact; otherwise the table yields 2*(2^p*1.m)^-1/2 in [1,2),
  // which costs one from the exponent.
  assign pow4_exp = $signed(8'(EXP_BIAS)) - k;
  assign tbl_exp  = pow4_exp - 8'sd1;

  // Priority-ordered special-case decode; the table path is the fall-through.
  always_comb begin
    special     = 1'b0;
    special_val = FP24_ZERO;
    addr        = {p, m[15:7]};
    res_exp     = tbl_exp[6:0];
    if (sign && (e != 7'd0)) begin
      special     = 1'b1;
      special_val = FP24_QNAN;
    end else if (e == 7'd0) begin
      special     = 1'b1;
      special_val = FP24_PINF;
    end else if ((e == 7'h7F) && (m != 16'd0)) begin
      special     = 1'b1;
      special_val = FP24_QNAN;
    end else if (e == 7'h7F) begin
      special     = 1'b1;
      special_val = FP24_ZERO;
    end else if (!p && (m == 16'd0)) begin
      special     = 1'b1;
      special_val = {1'b0, pow4_exp[6:0], 16'h0000};
    end
  end

endmodule

// File: rtl/sfu_lookup_frontend.sv
// SFU front end: classifies the operand, drives the RSQRT / TRANC ROM read port,
// and delivers side-band aligned with the ROM data (latency 2, one op per cycle).
module sfu_lookup_frontend #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 24,
  parameter int EXP_BIAS = 63
) (
  input  logic              core_clock_i,
  input  logic              core_reset_i,
  input  logic              flush_i,
  input  logic [DATA_W-1:0] core_operand,
  input  logic [2:0]        core_special_op,
  input  logic              valid,
  output logic              rsqrt_rd_en,
  output logic [ADDR_W-1:0] rsqrt_rd_addr,
  output logic              tranc_rd_en,
  output logic [ADDR_W-1:0] tranc_rd_addr,
  output logic              sb_valid,
  output logic              sb_special,
  output logic [DATA_W-1:0] sb_special_val,
  output logic              sb_sign,
  output logic [6:0]        sb_exp,
  output logic              sb_fmt
);
  import sfu_pkg::*;

  logic              cls_special;
  logic [23:0]       cls_val;
  logic [9:0]        cls_addr;
  logic [6:0]        cls_exp;

  logic              go;
  logic [1:0]        quad;
  logic [ADDR_W-1:0] idx;

  logic              vld_p1_d, vld_p1_q;
  logic              rsqrt_rd_en_d, rsqrt_rd_en_q;
  logic [ADDR_W-1:0] rsqrt_rd_addr_d, rsqrt_rd_addr_q;
  logic              tranc_rd_en_d, tranc_rd_en_q;
  logic [ADDR_W-1:0] tranc_rd_addr_d, tranc_rd_addr_q;
  sfu_sb_t           sb_p1_d, sb_p1_q;
  logic              sb_valid_d, sb_valid_q;
  sfu_sb_t           sb_p2_d, sb_p2_q;

  sfu_rsqrt_classify #(
    .EXP_BIAS (EXP_BIAS)
  ) u_classify (
    .operand     (core_operand),
    .special     (cls_special),
    .special_val (cls_val),
    .addr        (cls_addr),
    .res_exp     (cls_exp)
  );

  // S1 next state: op decode, ROM select and side-band for the presented operand.
  always_comb begin
    go   = valid & ~flush_i;
    quad = core_operand[23:22];
    if (core_special_op == SFU_COS) quad = quad + 2'd1;
    idx  = core_operand[21:12];

    vld_p1_d        = go;
    rsqrt_rd_en_d   = 1'b0;
    tranc_rd_en_d   = 1'b0;
    rsqrt_rd_addr_d = cls_addr;
    // Odd quadrants run the quarter-wave table backwards.
    tranc_rd_addr_d = quad[0] ? ~idx : idx;
    sb_p1_d         = '0;

    case (core_special_op)
      SFU_RSQRT: begin
        sb_p1_d.special     = cls_special;
        sb_p1_d.special_val = cls_val;
        sb_p1_d.exp         = cls_exp;
        rsqrt_rd_en_d       = go & ~cls_special;
      end
      SFU_SIN, SFU_COS: begin
        // Peak of the wave lies one past the end of the table: return 1.0 directly.
        sb_p1_d.special     = quad[0] && (idx == '0);
        sb_p1_d.special_val = FIX_ONE;
        sb_p1_d.sign        = quad[1];
        sb_p1_d.fmt         = 1'b1;
        tranc_rd_en_d       = go & ~sb_p1_d.special;
      end
      default: begin
        sb_p1_d.special     = 1'b1;
        sb_p1_d.special_val = FP24_ZERO;
      end
    endcase
  end

  // S2 next state: side-band follows the ROM's one-cycle read; flush kills the op in S1.
  always_comb begin
    sb_valid_d = vld_p1_q & ~flush_i;
    sb_p2_d    = sb_p1_q;
  end

  // S1 registers: ROM read port and stage-1 side-band.
  always_ff @(posedge core_clock_i or posedge core_reset_i) begin
    if (core_reset_i) begin
      vld_p1_q        <= 1'b0;
      rsqrt_rd_en_q   <= 1'b0;
      rsqrt_rd_addr_q <= '0;
      tranc_rd_en_q   <= 1'b0;
      tranc_rd_addr_q <= '0;
      sb_p1_q         <= '0;
    end else begin
      vld_p1_q        <= vld_p1_d;
      rsqrt_rd_en_q   <= rsqrt_rd_en_d;
      rsqrt_rd_addr_q <= rsqrt_rd_addr_d;
      tranc_rd_en_q   <= tranc_rd_en_d;
      tranc_rd_addr_q <= tranc_rd_addr_d;
      sb_p1_q         <= sb_p1_d;
    end
  end

  // S2 registers: side-band presented alongside ROM rd_data.
  always_ff @(posedge core_clock_i or posedge core_reset_i) begin
    if (core_reset_i) begin
      sb_valid_q <= 1'b0;
      sb_p2_q    <= '0;
    end else begin
      sb_valid_q <= sb_valid_d;
      sb_p2_q    <= sb_p2_d;
    end
  end

  assign rsqrt_rd_en    = rsqrt_rd_en_q;
  assign rsqrt_rd_addr  = rsqrt_rd_addr_q;
  assign tranc_rd_en    = tranc_rd_en_q;
  assign tranc_rd_addr  = tranc_rd_addr_q;
  // A flush also suppresses the op leaving S2 that cycle, so nothing issued
  // before the flush is reported downstream.
  assign sb_valid       = sb_valid_q & ~flush_i;
  assign sb_special     = sb_p2_q.special;
  assign sb_special_val = sb_p2_q.special_val;
  assign sb_sign        = sb_p2_q.sign;
  assign sb_exp         = sb_p2_q.exp;
  assign sb_fmt         = sb_p2_q.fmt;

endmodule

// File: tb/tb_sfu_lookup_frontend.sv
// Directed bench for sfu_lookup_frontend with a cycle-tagged scoreboard.
module tb_sfu_lookup_frontend;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [23:0] operand;
  logic [2:0]  op;
  logic        vld;
  logic        rsqrt_rd_en;
  logic [9:0]  rsqrt_rd_addr;
  logic        tranc_rd_en;
  logic [9:0]  tranc_rd_addr;
  logic        sb_valid;
  logic        sb_special;
  logic [23:0] sb_special_val;
  logic        sb_sign;
  logic [6:0]  sb_exp;
  logic        sb_fmt;

  sfu_lookup_frontend dut (
    .core_clock_i    (clk),
    .core_reset_i    (rst),
    .flush_i         (flush),
    .core_operand    (operand),
    .core_special_op (op),
    .valid           (vld),
    .rsqrt_rd_en     (rsqrt_rd_en),
    .rsqrt_rd_addr   (rsqrt_rd_addr),
    .tranc_rd_en     (tranc_rd_en),
    .tranc_rd_addr   (tranc_rd_addr),
    .sb_valid        (sb_valid),
    .sb_special      (sb_special),
    .sb_special_val  (sb_special_val),
    .sb_sign         (sb_sign),
    .sb_exp          (sb_exp),
    .sb_fmt          (sb_fmt)
  );

  typedef struct {
    int         due;
    logic       rs_en;
    logic [9:0] rs_addr;
    logic       tr_en;
    logic [9:0] tr_addr;
  } rd_exp_t;

  typedef struct {
    int          due;
    logic        special;
    logic [23:0] sval;
    logic [2:0]  msk;   // {check sign, check exp, check fmt}
    logic        sign;
    logic [6:0]  exp;
    logic        fmt;
  } sb_exp_t;

  rd_exp_t rdq[$];
  sb_exp_t sbq[$];
  rd_exp_t re;
  sb_exp_t se;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Per-cycle monitor, sampling mid-way between clock edges.
  always @(posedge clk) begin
    #3;
    if (rdq.size() > 0 && rdq[0].due == cyc) begin
      re = rdq.pop_front();
      chk("rsqrt_rd_en", 32'(rsqrt_rd_en), 32'(re.rs_en));
      chk("tranc_rd_en", 32'(tranc_rd_en), 32'(re.tr_en));
      if (re.rs_en) chk("rsqrt_rd_addr", 32'(rsqrt_rd_addr), 32'(re.rs_addr));
      if (re.tr_en) chk("tranc_rd_addr", 32'(tranc_rd_addr), 32'(re.tr_addr));
    end else begin
      chk("rsqrt_rd_en_idle", 32'(rsqrt_rd_en), 32'd0);
      chk("tranc_rd_en_idle", 32'(tranc_rd_en), 32'd0);
    end
    if (sbq.size() > 0 && sbq[0].due == cyc) begin
      se = sbq.pop_front();
      chk("sb_valid", 32'(sb_valid), 32'd1);
      chk("sb_special", 32'(sb_special), 32'(se.special));
      if (se.special) chk("sb_special_val", 32'(sb_special_val), 32'(se.sval));
      if (se.msk[2]) chk("sb_sign", 32'(sb_sign), 32'(se.sign));
      if (se.msk[1]) chk("sb_exp", 32'(sb_exp), 32'(se.exp));
      if (se.msk[0]) chk("sb_fmt", 32'(sb_fmt), 32'(se.fmt));
    end else begin
      chk("sb_valid_idle", 32'(sb_valid), 32'd0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    vld   = 1'b0;
    flush = 1'b0;
  endtask

  task automatic drive(input logic [2:0] o, input logic [23:0] x, input logic fl);
    vld     = 1'b1;
    op      = o;
    operand = x;
    flush   = fl;
  endtask

  task automatic issue(input logic [2:0] o, input logic [23:0] x,
                       input logic rs_en, input logic [9:0] rs_addr,
                       input logic tr_en, input logic [9:0] tr_addr,
                       input logic special, input logic [23:0] sval,
                       input logic [2:0] msk, input logic sign,
                       input logic [6:0] exp, input logic fmt);
    rd_exp_t r;
    sb_exp_t s;
    drive(o, x, 1'b0);
    r.due = cyc + 1; r.rs_en = rs_en; r.rs_addr = rs_addr; r.tr_en = tr_en; r.tr_addr = tr_addr;
    s.due = cyc + 2; s.special = special; s.sval = sval; s.msk = msk;
    s.sign = sign; s.exp = exp; s.fmt = fmt;
    rdq.push_back(r);
    sbq.push_back(s);
  endtask

  task automatic check_all_zero(input string where);
    chk({where, "_rsqrt_rd_en"}, 32'(rsqrt_rd_en), 32'd0);
    chk({where, "_rsqrt_rd_addr"}, 32'(rsqrt_rd_addr), 32'd0);
    chk({where, "_tranc_rd_en"}, 32'(tranc_rd_en), 32'd0);
    chk({where, "_tranc_rd_addr"}, 32'(tranc_rd_addr), 32'd0);
    chk({where, "_sb_valid"}, 32'(sb_valid), 32'd0);
    chk({where, "_sb_special"}, 32'(sb_special), 32'd0);
    chk({where, "_sb_special_val"}, 32'(sb_special_val), 32'd0);
    chk({where, "_sb_sign"}, 32'(sb_sign), 32'd0);
    chk({where, "_sb_exp"}, 32'(sb_exp), 32'd0);
    chk({where, "_sb_fmt"}, 32'(sb_fmt), 32'd0);
  endtask

  initial begin
    rst     = 1'b1;
    flush   = 1'b0;
    vld     = 1'b0;
    op      = 3'd0;
    operand = 24'd0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    // RSQRT: exact powers of four, table path, and the special classes.
    step(); issue(3'd0, 24'h410000, 0, 10'h000, 0, 10'h000, 1, 24'h3E0000, 3'b000, 0, 7'd0,  0);
    step(); issue(3'd0, 24'h400000, 1, 10'h200, 0, 10'h000, 0, 24'h000000, 3'b111, 0, 7'd62, 0);
    step(); issue(3'd0, 24'hBF0000, 0, 10'h000, 0, 10'h000, 1, 24'h7F8000, 3'b000, 0, 7'd0,  0);
    step(); issue(3'd0, 24'h000000, 0, 10'h000, 0, 10'h000, 1, 24'h7F0000, 3'b000, 0, 7'd0,  0);
    step(); issue(3'd0, 24'h7F0000, 0, 10'h000, 0, 10'h000, 1, 24'h000000, 3'b000, 0, 7'd0,  0);
    step(); issue(3'd0, 24'h7F8001, 0, 10'h000, 0, 10'h000, 1, 24'h7F8000, 3'b000, 0, 7'd0,  0);
    step(); issue(3'd0, 24'h41A380, 1, 10'h147, 0, 10'h000, 0, 24'h000000, 3'b111, 0, 7'd61, 0);
    step(); issue(3'd0, 24'h3D4000, 1, 10'h080, 0, 10'h000, 0, 24'h000000, 3'b111, 0, 7'd63, 0);
    step(); issue(3'd0, 24'h3C0080, 1, 10'h201, 0, 10'h000, 0, 24'h000000, 3'b111, 0, 7'd64, 0);
    step(); issue(3'd0, 24'h3D0000, 0, 10'h000, 0, 10'h000, 1, 24'h400000, 3'b000, 0, 7'd0,  0);

    // SIN / COS: quadrant folding, mirrored addressing, peak-of-wave special.
    step(); issue(3'd1, 24'h500000, 0, 10'h000, 1, 10'h2FF, 0, 24'h000000, 3'b101, 0, 7'd0, 1);
    step(); issue(3'd2, 24'h500000, 0, 10'h000, 1, 10'h100, 0, 24'h000000, 3'b101, 1, 7'd0, 1);
    step(); issue(3'd1, 24'h400000, 0, 10'h000, 0, 10'h000, 1, 24'h010000, 3'b101, 0, 7'd0, 1);
    step(); issue(3'd1, 24'hC00000, 0, 10'h000, 0, 10'h000, 1, 24'h010000, 3'b101, 1, 7'd0, 1);
    step(); issue(3'd2, 24'h7FF000, 0, 10'h000, 1, 10'h3FF, 0, 24'h000000, 3'b101, 1, 7'd0, 1);
    step(); issue(3'd2, 24'h000000, 0, 10'h000, 0, 10'h000, 1, 24'h010000, 3'b101, 0, 7'd0, 1);
    step(); idle();
    repeat (3) step();

    // Flush: A, B in flight, C presented with flush; D follows.
    step(); issue(3'd0, 24'h400000, 1, 10'h200, 0, 10'h000, 0, 24'h000000, 3'b111, 0, 7'd62, 0);
    step(); issue(3'd1, 24'h500000, 0, 10'h000, 1, 10'h2FF, 0, 24'h000000, 3'b101, 0, 7'd0, 1);
    step(); drive(3'd2, 24'h500000, 1'b1);
    while (sbq.size() > 0 && sbq[$].due >= cyc) void'(sbq.pop_back());
    while (rdq.size() > 0 && rdq[$].due > cyc) void'(rdq.pop_back());
    step(); issue(3'd0, 24'h410000, 0, 10'h000, 0, 10'h000, 1, 24'h3E0000, 3'b000, 0, 7'd0, 0);

    // Reserved op codes.
    step(); issue(3'd5, 24'h400000, 0, 10'h000, 0, 10'h000, 1, 24'h000000, 3'b001, 0, 7'd0, 0);
    step(); issue(3'd7, 24'h123456, 0, 10'h000, 0, 10'h000, 1, 24'h000000, 3'b001, 0, 7'd0, 0);
    step(); idle();
    repeat (3) step();

    // Reset while an RSQRT 2.0 is between S1 and S2.
    step(); issue(3'd0, 24'h400000, 1, 10'h200, 0, 10'h000, 0, 24'h000000, 3'b111, 0, 7'd62, 0);
    step(); idle();
    #4;
    rst = 1'b1;
    rdq.delete();
    sbq.delete();
    #1;
    check_all_zero("midreset");
    step();
    #4;
    rst = 1'b0;
    repeat (3) step();

    // Operation resumes after reset.
    step(); issue(3'd2, 24'h500000, 0, 10'h000, 1, 10'h100, 0, 24'h000000, 3'b101, 1, 7'd0, 1);
    step(); idle();

    for (int i = 0; i < 10 && (rdq.size() > 0 || sbq.size() > 0); i++) @(posedge clk);
    #5;
    chk("drain_rd", 32'(rdq.size()), 32'd0);
    chk("drain_sb", 32'(sbq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
